// File: rtl/bkm_steps_ctrl_pkg.sv
// Shared BKM definitions: controller FSM states, operand format codes and mode codes.
package bkm_steps_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_STEP  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } bkm_state_e;

    localparam logic MODE_E = 1'b0;
    localparam logic MODE_L = 1'b1;

    localparam logic [1:0] FMT_0    = 2'b00;
    localparam logic [1:0] FMT_1    = 2'b01;
    localparam logic [1:0] FMT_2    = 2'b10;
    localparam logic [1:0] FMT_RSVD = 2'b11;

    function automatic logic fmt_reserved(input logic [1:0] fmt);
        return fmt == FMT_RSVD;
    endfunction

endpackage

// File: rtl/bkm_step_counter.sv
// Step/drain counter: synchronous clear, enable-gated wrapping increment and a
// terminal-count flag against a run-time last value.
module bkm_step_counter #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         arst,
    input  logic         en,
    input  logic         clear,
    input  logic         inc,
    input  logic [W-1:0] last,
    output logic [W-1:0] count,
    output logic         tc
);

    assign tc = (count == last);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            count <= '0;
        end else if (en) begin
            if (clear) begin
                count <= '0;
            end else if (inc) begin
                count <= tc ? '0 : count + W'(1);
            end
        end
    end

endmodule

// File: rtl/bkm_steps_ctrl.sv
// BKM iteration controller: sequences operand load, N iteration steps and the
// datapath drain, with abort, clock-enable stall and reserved-format rejection.
module bkm_steps_ctrl
    import bkm_steps_ctrl_pkg::*;
#(
    parameter int WC    = 16,
    parameter int WD    = 64,
    parameter int LOG2N = 6,
    parameter int LAT   = 1
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             enable,
    input  logic             start,
    input  logic             abort,
    input  logic             mode,
    input  logic [1:0]       format,
    output logic             busy,
    output logic             load,
    output logic             step_en,
    output logic [LOG2N-1:0] step_idx,
    output logic             mode_q,
    output logic [1:0]       format_q,
    output logic             done,
    output logic             aborted,
    output logic             err_fmt
);

    localparam int N          = 1 << LOG2N;
    localparam int CW         = (LOG2N > 3) ? LOG2N : 3;
    localparam int DRAIN_LAST = (LAT > 0) ? LAT - 1 : 0;

    // WC/WD only travel with the datapath; this empty guard names unsupported configurations.
    if (WC < 1 || WD < 1 || LAT < 0 || LAT > 7) begin : g_unsupported_config
    end

    bkm_state_e    state_q, state_d;
    logic          capture;
    logic          abort_ok;
    logic          err_d;
    logic          aborted_q;
    logic          err_q;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_last;
    logic          cnt_tc;

    // One counter serves both phases; its terminal value follows the state.
    assign cnt_last = (state_q == ST_STEP) ? CW'(N - 1) : CW'(DRAIN_LAST);

    bkm_step_counter #(.W(CW)) u_counter (
        .clk   (clk),
        .arst  (arst),
        .en    (enable),
        .clear (abort_ok),
        .inc   ((state_q == ST_STEP) || (state_q == ST_DRAIN)),
        .last  (cnt_last),
        .count (cnt),
        .tc    (cnt_tc)
    );

    // NOTE: async reset covers only control state; every sequential update uses <= so
    // all registers sample the same pre-edge values.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q   <= ST_IDLE;
            mode_q    <= 1'b0;
            format_q  <= 2'b00;
            aborted_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                mode_q   <= mode;
                format_q <= format;
            end
            if (enable) begin
                aborted_q <= abort_ok;
                err_q     <= err_d;
            end
        end
    end

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        abort_ok = 1'b0;
        err_d    = 1'b0;
        if (enable) begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        if (fmt_reserved(format)) begin
                            err_d = 1'b1;
                        end else begin
                            state_d = ST_LOAD;
                            capture = 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (abort) abort_ok = 1'b1;
                    else       state_d  = ST_STEP;
                end
                ST_STEP: begin
                    if (abort)       abort_ok = 1'b1;
                    else if (cnt_tc) state_d  = (LAT > 0) ? ST_DRAIN : ST_DONE;
                end
                ST_DRAIN: begin
                    if (abort)       abort_ok = 1'b1;
                    else if (cnt_tc) state_d  = ST_DONE;
                end
                ST_DONE: begin
                    // done is already committed, so abort has no effect here
                    if (start && !fmt_reserved(format)) begin
                        state_d = ST_LOAD;
                        capture = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            if (abort_ok) state_d = ST_IDLE;
        end
    end

    always_comb begin
        busy     = (state_q != ST_IDLE);
        load     = enable && (state_q == ST_LOAD);
        step_en  = enable && (state_q == ST_STEP);
        done     = enable && (state_q == ST_DONE);
        aborted  = enable && aborted_q;
        err_fmt  = enable && err_q;
        step_idx = (state_q == ST_STEP) ? cnt[LOG2N-1:0] : '0;
    end

endmodule

// File: tb/tb_bkm_steps_ctrl.sv
// Randomized scoreboard bench for bkm_steps_ctrl against a timeline model counted in enabled cycles.
module tb_bkm_steps_ctrl;
    import bkm_steps_ctrl_pkg::*;

    localparam int LOG2N = 2;
    localparam int LAT   = 1;
    localparam int N     = 1 << LOG2N;

    localparam logic [4:0] K_LOAD = 5'b10000;
    localparam logic [4:0] K_STEP = 5'b01000;
    localparam logic [4:0] K_DONE = 5'b00100;
    localparam logic [4:0] K_ABT  = 5'b00010;
    localparam logic [4:0] K_ERR  = 5'b00001;

    logic             clk = 1'b0;
    logic             arst, enable, start, abort, mode;
    logic [1:0]       format;
    logic             busy, load, step_en, done, aborted, err_fmt, mode_q;
    logic [LOG2N-1:0] step_idx;
    logic [1:0]       format_q;

    typedef struct {
        int         t;
        logic [4:0] kind;
        int         idx;
        bit         has_cfg;
        logic       md;
        logic [1:0] fm;
    } ev_t;

    ev_t q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  ecount   = 0;
    bit  prev_en  = 1'b0;
    bit  mon_on   = 1'b0;
    bit  act      = 1'b0;
    int  t_start  = 0;
    int  t_done   = 0;
    bit  exp_busy = 1'b0;
    int  exp_idx  = 0;

    bkm_steps_ctrl #(.WC(16), .WD(64), .LOG2N(LOG2N), .LAT(LAT)) dut (
        .clk      (clk),
        .arst     (arst),
        .enable   (enable),
        .start    (start),
        .abort    (abort),
        .mode     (mode),
        .format   (format),
        .busy     (busy),
        .load     (load),
        .step_en  (step_en),
        .step_idx (step_idx),
        .mode_q   (mode_q),
        .format_q (format_q),
        .done     (done),
        .aborted  (aborted),
        .err_fmt  (err_fmt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (enabled cycle %0d, t=%0t)", name, got, exp, ecount, $time);
        end
    endtask

    task automatic push(input int t, input logic [4:0] kind, input int idx, input bit has_cfg,
                        input logic md, input logic [1:0] fm);
        ev_t ev;
        ev.t = t; ev.kind = kind; ev.idx = idx; ev.has_cfg = has_cfg; ev.md = md; ev.fm = fm;
        q.push_back(ev);
    endtask

    // An accepted evaluation at enabled cycle a: load at a+1, steps a+2..a+N+1, done at a+N+LAT+2.
    task automatic accept(input int a, input logic md, input logic [1:0] fm);
        act     = 1'b1;
        t_start = a;
        t_done  = a + N + LAT + 2;
        push(a + 1, K_LOAD, 0, 1'b1, md, fm);
        for (int k = 0; k < N; k++) push(a + 2 + k, K_STEP, k, 1'b1, md, fm);
        push(t_done, K_DONE, 0, 1'b1, md, fm);
    endtask

    task automatic cyc(input bit en, input bit st, input bit ab, input logic md, input logic [1:0] fm);
        bit idle, in_done, mid;
        @(posedge clk);
        #1;
        if (prev_en) ecount++;
        prev_en = en;
        idle    = !act || (ecount > t_done);
        in_done = act && (ecount == t_done);
        mid     = act && (ecount > t_start) && (ecount < t_done);
        exp_busy = !idle;
        exp_idx  = (act && ecount >= t_start + 2 && ecount <= t_start + N + 1) ? ecount - t_start - 2 : 0;
        if (en) begin
            if (st && fm != FMT_RSVD && ((idle && !ab) || in_done)) begin
                accept(ecount, md, fm);
            end else if (idle && st && !ab && fm == FMT_RSVD) begin
                push(ecount + 1, K_ERR, 0, 1'b0, 1'b0, 2'b00);
            end else if (mid && ab) begin
                while (q.size() > 0 && q[$].t > ecount) void'(q.pop_back());
                push(ecount + 1, K_ABT, 0, 1'b0, 1'b0, 2'b00);
                act = 1'b0;
            end
        end
        enable = en;
        start  = st;
        abort  = ab;
        mode   = md;
        format = fm;
    endtask

    task automatic check_reset_outputs(input string p);
        check({p, "_busy"},     busy,     0);
        check({p, "_load"},     load,     0);
        check({p, "_step_en"},  step_en,  0);
        check({p, "_done"},     done,     0);
        check({p, "_aborted"},  aborted,  0);
        check({p, "_err_fmt"},  err_fmt,  0);
        check({p, "_step_idx"}, step_idx, 0);
        check({p, "_mode_q"},   mode_q,   0);
        check({p, "_format_q"}, format_q, 0);
    endtask

    // Reset pulse between edges, after a cycle that drove neither start nor abort.
    task automatic reset_mid();
        #1 arst = 1'b1;
        #1 check_reset_outputs("mid_reset");
        q.delete();
        act      = 1'b0;
        exp_busy = 1'b0;
        exp_idx  = 0;
        #1 arst = 1'b0;
    endtask

    always @(negedge clk) begin
        logic [4:0] strobes;
        ev_t        ev;
        if (mon_on && !arst) begin
            strobes = {load, step_en, done, aborted, err_fmt};
            check("busy", busy, exp_busy);
            check("step_idx", step_idx, exp_idx);
            if (!enable) begin
                check("gated_strobes", strobes, 0);
            end else if (q.size() > 0 && q[0].t == ecount) begin
                ev = q.pop_front();
                check("strobe_kind", strobes, ev.kind);
                if (ev.kind == K_STEP) check("step_event_idx", step_idx, ev.idx);
                if (ev.has_cfg) begin
                    check("mode_q", mode_q, ev.md);
                    check("format_q", format_q, ev.fm);
                end
            end else begin
                check("no_strobe", strobes, 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        arst = 1'b1; enable = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0; format = 2'b00;
        #12;
        check_reset_outputs("por");
        @(posedge clk);
        #3 arst = 1'b0;
        mon_on = 1'b1;

        // nominal, then back-to-back start in DONE, then abort at step_idx 2
        cyc(1, 1, 0, MODE_L, FMT_1);
        repeat (6) cyc(1, 0, 0, MODE_E, FMT_0);
        cyc(1, 1, 0, MODE_E, FMT_2);
        repeat (3) cyc(1, 0, 0, MODE_E, FMT_0);
        cyc(1, 0, 1, MODE_E, FMT_0);
        cyc(1, 0, 0, MODE_E, FMT_0);

        // reserved format, then start+abort together in IDLE
        cyc(1, 1, 0, MODE_L, FMT_RSVD);
        cyc(1, 0, 0, MODE_E, FMT_0);
        cyc(1, 1, 1, MODE_L, FMT_0);
        cyc(1, 0, 0, MODE_E, FMT_0);

        // enable stall of 3 cycles at step_idx 1
        cyc(1, 1, 0, MODE_L, FMT_2);
        repeat (2) cyc(1, 0, 0, MODE_E, FMT_0);
        repeat (3) cyc(0, 1, 1, MODE_E, FMT_0);
        repeat (8) cyc(1, 0, 0, MODE_E, FMT_0);

        // asynchronous reset mid-STEP, then a full evaluation
        cyc(1, 1, 0, MODE_L, FMT_1);
        repeat (3) cyc(1, 0, 0, MODE_E, FMT_0);
        reset_mid();
        cyc(1, 1, 0, MODE_E, FMT_1);
        repeat (9) cyc(1, 0, 0, MODE_E, FMT_0);

        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 250) begin
                cyc(1, 0, 0, MODE_E, FMT_0);
                reset_mid();
            end else begin
                cyc($urandom_range(0, 7) != 0,
                    $urandom_range(0, 2) == 0,
                    $urandom_range(0, 24) == 0,
                    $urandom_range(0, 1) != 0 ? MODE_L : MODE_E,
                    2'($urandom_range(0, 3)));
            end
        end

        repeat (12) cyc(1, 0, 0, MODE_E, FMT_0);
        @(negedge clk);
        #1;
        check("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
